// File: rtl/decl_rr_arbiter_if.sv
// Requester-side bundle for decl_rr_arbiter: request/accept, response/ready, owner index and busy flag.
interface decl_rr_arbiter_if #(
  parameter int N = 4
);
  localparam int GW = $clog2(N);

  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_x;
  logic [N-1:0]  req_y;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  resp_valid;
  logic [N-1:0]  resp_ready;
  logic          resp_x;
  logic          resp_y;
  logic [GW-1:0] grant_id;
  logic          busy;

  modport master (
    output req_valid, req_x, req_y, resp_ready,
    input  req_ready, resp_valid, resp_x, resp_y, grant_id, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, resp_ready,
    output req_ready, resp_valid, resp_x, resp_y, grant_id, busy
  );
endinterface

// File: rtl/decl_rr_arbiter.sv
// Round-robin sequencer sharing one external Decl among N requesters; response DECL_LATENCY+2 cycles after accept,
// RESP held indefinitely under backpressure. Define DECL_ARB_B2B_EN to re-arbitrate in the response handshake cycle.
module decl_rr_arbiter #(
  parameter int  N            = 4,
  parameter int  DECL_LATENCY = 0,
  localparam int GW           = $clog2(N),
  localparam int CW           = (DECL_LATENCY > 0) ? $clog2(DECL_LATENCY + 1) : 1
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  decl_rr_arbiter_if.slave bus,
  output logic             decl_I_x,
  output logic             decl_I_y,
  input  logic             decl_O_x,
  input  logic             decl_O_y
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] last_grant, last_grant_nxt;
  logic [GW-1:0] grant, grant_nxt;
  logic          in_x, in_x_nxt, in_y, in_y_nxt;
  logic          out_x, out_x_nxt, out_y, out_y_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          resp_hs;
  logic          arb_en;
  logic [GW-1:0] arb_base;
  logic          win_vld;
  logic [GW-1:0] win_idx;
  logic [GW:0]   scan;
  logic          accept;

  assign resp_hs = (state == RESP) && bus.resp_ready[grant];

  // Arbitration is suppressed while reset is held so req_ready reads 0 during reset.
  always_comb begin
    arb_en   = 1'b0;
    arb_base = last_grant;
    if (!ASYNCRESET) begin
      if (state == IDLE) begin
        arb_en = 1'b1;
      end
`ifdef DECL_ARB_B2B_EN
      else if (resp_hs) begin
        arb_en   = 1'b1;
        arb_base = grant;
      end
`endif
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan    = '0;
    for (int i = 1; i <= N; i++) begin
      scan = {1'b0, arb_base} + (GW+1)'(i);
      if (scan >= (GW+1)'(N)) begin
        scan = scan - (GW+1)'(N);
      end
      if (!win_vld && bus.req_valid[scan[GW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan[GW-1:0];
      end
    end
  end

  assign accept = arb_en && win_vld;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_nxt      = grant;
    in_x_nxt       = in_x;
    in_y_nxt       = in_y;
    out_x_nxt      = out_x;
    out_y_nxt      = out_y;
    cnt_nxt        = cnt;
    unique case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      WAIT: begin
        if (cnt == '0) begin
          out_x_nxt = decl_O_x;
          out_y_nxt = decl_O_y;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      RESP: begin
        if (resp_hs) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Accept can only fire from IDLE or, with back-to-back enabled, the RESP handshake cycle.
    if (accept) begin
      in_x_nxt  = bus.req_x[win_idx];
      in_y_nxt  = bus.req_y[win_idx];
      grant_nxt = win_idx;
      cnt_nxt   = CW'(DECL_LATENCY);
      state_nxt = WAIT;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state      <= IDLE;
      last_grant <= GW'(N - 1);
      grant      <= '0;
      in_x       <= 1'b0;
      in_y       <= 1'b0;
      out_x      <= 1'b0;
      out_y      <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant      <= grant_nxt;
      in_x       <= in_x_nxt;
      in_y       <= in_y_nxt;
      out_x      <= out_x_nxt;
      out_y      <= out_y_nxt;
      cnt        <= cnt_nxt;
    end
  end

  assign bus.req_ready  = accept ? (N'(1) << win_idx) : '0;
  assign bus.resp_valid = (state == RESP) ? (N'(1) << grant) : '0;
  assign bus.resp_x     = out_x;
  assign bus.resp_y     = out_y;
  assign bus.grant_id   = grant;
  assign bus.busy       = (state != IDLE);
  assign decl_I_x       = in_x;
  assign decl_I_y       = in_y;

endmodule

// File: doc/decl_rr_arbiter.md
Name: decl_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one externally-defined `my_namespace__Decl` instance (1-bit x/y tuple in, 1-bit x/y tuple out) among N requesters. The Decl instance sits outside this block and connects through the decl_* ports. The block accepts one request at a time, holds the Decl inputs stable for the configured latency, captures the result and returns it to the granted requester with a valid/ready handshake. It sits one level above the existing Foo/Bar wrappers in `my_namespace`.

Parameters:
N, 4, number of requesters; legal range 2..16.
DECL_LATENCY, 0, cycles from stable decl_I_* to valid decl_O_*; legal range 0..15.
GW, $clog2(N), width of the grant index (derived, not user-set).

Ports:
CLK  input  1  clock, rising edge.
ASYNCRESET  input  1  asynchronous reset, active-high.
req_valid  input  N  per-requester request valid.
req_x  input  N  per-requester I_x bit.
req_y  input  N  per-requester I_y bit.
req_ready  output  N  one-hot accept strobe.
resp_valid  output  N  one-hot response valid.
resp_ready  input  N  per-requester response ready.
resp_x  output  1  shared response O_x bit.
resp_y  output  1  shared response O_y bit.
grant_id  output  GW  index of the current owner.
busy  output  1  high whenever state is not IDLE.
decl_I_x  output  1  to the Decl I_x input.
decl_I_y  output  1  to the Decl I_y input.
decl_O_x  input  1  from the Decl O_x output.
decl_O_y  input  1  from the Decl O_y output.

Behaviour:
- Clock and reset: single clock CLK. ASYNCRESET is asynchronous, active-high.
- Reset values:
  - State IDLE; last_grant = N-1, so requester 0 wins first.
  - in_x, in_y, out_x, out_y, cnt, grant_id all 0.
  - req_ready, resp_valid and busy all 0.
- Reset asserted mid-transaction: the in-flight request is dropped and no response is issued.
- Decl drive: decl_I_x = in_x and decl_I_y = in_y, registered. They are stable through WAIT.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req_valid != 0, pick g = first set bit scanning from (last_grant+1) mod N upward with wrap.
  - req_ready[g] = 1 combinationally in that cycle. This is the accept.
  - On the clock edge: in_x <= req_x[g], in_y <= req_y[g], grant_id <= g, cnt <= DECL_LATENCY, go to WAIT.
  - req_ready is 0 in every other state.
- WAIT:
  - If cnt == 0: out_x <= decl_O_x, out_y <= decl_O_y, go to RESP.
  - Otherwise cnt <= cnt-1.
- RESP:
  - resp_valid[grant_id] = 1; resp_x = out_x, resp_y = out_y.
  - When resp_ready[grant_id] = 1: handshake completes, last_grant <= grant_id, go to IDLE.
  - resp_ready of non-owners is ignored.
- Latency: resp_valid rises DECL_LATENCY+2 cycles after the accept edge.
- Outside RESP: resp_valid = 0; resp_x and resp_y are held at out_x/out_y and carry no meaning.
- Requester rules: req_valid must hold until req_ready. Data is sampled only in the accept cycle. A request dropped before accept is never served.
- Simultaneous requests: exactly one is accepted per arbitration. Rotation guarantees each of N continuous requesters is served within N transactions.
- Backpressure: RESP holds indefinitely with stable resp_x/resp_y and one-hot resp_valid.

Optional Feature:
Macro DECL_ARB_B2B_EN.
- Defined: in RESP, the same cycle the response handshake completes, arbitration runs immediately using the updated rotation base (grant_id+1).
  - If any req_valid is set, the winner gets req_ready that cycle and the FSM goes directly to WAIT.
  - Throughput becomes one transaction per DECL_LATENCY+2 cycles.
- Undefined: RESP always returns to IDLE; throughput is one transaction per DECL_LATENCY+3 cycles.

Test Plan:
1. Single request: N=4, L=0, req_valid=0b0100, x=1, y=0, Decl modelled as swap (O_x=I_y, O_y=I_x). Expect req_ready=0b0100 in the accept cycle, resp_valid=0b0100 two cycles later, resp_x=0, resp_y=1.
2. Fairness: req_valid=0b1111 held continuously, resp_ready=1111. Expect grants 0,1,2,3,0 in order, and grant_id matches each resp_valid.
3. Backpressure: resp_ready low for 5 cycles in RESP. Expect resp_valid, resp_x and resp_y stable for all 5 cycles, and no req_ready during that time.
4. Latency: DECL_LATENCY=3, one request. Expect decl_I_* stable for 4 cycles, and resp_valid exactly 5 cycles after the accept edge.
5. Reset mid-WAIT: assert ASYNCRESET for 1 cycle during WAIT. Expect all outputs 0 immediately, state IDLE, and the next grant going to requester 0.
6. B2B (macro on): req_valid=0b0011 held. Expect the second accept in the same cycle as the first response handshake, and a 2-cycle transaction spacing at L=0.
